// File: rtl/divide_if.sv
// Operand/result handshake bundle for the iterative divider.
// master = producer of operands and consumer of results; slave = divider.
interface divide_if #(
  parameter int A_W = 18,
  parameter int B_W = 18
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] q;
  logic [B_W-1:0] r;
  logic           div_by_zero;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, q, r, div_by_zero);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, q, r, div_by_zero);
endinterface

// File: rtl/divide.sv
// Restoring divider, one quotient bit per clock, on magnitudes.
// Signs are re-applied in a fix-up cycle, so signed results truncate toward zero.
module divide #(
  parameter int G_A_WIDTH = 18,
  parameter int G_B_WIDTH = 18,
  parameter int G_SIGNED  = 0
) (
  input logic     clk,
  input logic     rst,
  divide_if.slave bus
);
  localparam int AW = G_A_WIDTH;
  localparam int BW = G_B_WIDTH;
  localparam int CW = $clog2(AW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;

  logic [AW-1:0] dvd, a_raw, q;
  logic [BW-1:0] bmag, rem, r, r_dbz;
  logic [CW-1:0] cnt;
  logic          sign_q, sign_r, b_zero;
  logic          in_ready, out_valid, dbz;

  logic          sa, sb;
  logic [AW-1:0] amag;
  logic [BW-1:0] bm_in;
  logic [BW:0]   rem_sh, diff;

  always_comb begin
    sa     = (G_SIGNED != 0) && bus.a[AW-1];
    sb     = (G_SIGNED != 0) && bus.b[BW-1];
    amag   = sa ? -bus.a : bus.a;
    bm_in  = sb ? -bus.b : bus.b;
    rem_sh = {rem, dvd[AW-1]};
    diff   = rem_sh - {1'b0, bmag};
  end

  // Divide-by-zero returns the raw dividend as remainder, fitted to the remainder width.
  if (AW >= BW) begin : g_rdz_trunc
    assign r_dbz = a_raw[BW-1:0];
  end else begin : g_rdz_ext
    assign r_dbz = {{(BW-AW){(G_SIGNED != 0) && a_raw[AW-1]}}, a_raw};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      dbz       <= 1'b0;
      cnt       <= '0;
      dvd       <= '0;
      a_raw     <= '0;
      bmag      <= '0;
      rem       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      b_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (bus.in_valid && in_ready) begin
            in_ready <= 1'b0;
            dvd      <= amag;
            a_raw    <= bus.a;
            bmag     <= bm_in;
            sign_q   <= sa ^ sb;
            sign_r   <= sa;
            b_zero   <= (bus.b == '0);
            rem      <= '0;
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
          if (!diff[BW]) begin
            rem <= diff[BW-1:0];
            dvd <= {dvd[AW-2:0], 1'b1};
          end else begin
            rem <= rem_sh[BW-1:0];
            dvd <= {dvd[AW-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(AW - 1)) state <= FIX;
        end
        FIX: begin
          q     <= b_zero ? '1    : (sign_q ? -dvd : dvd);
          r     <= b_zero ? r_dbz : (sign_r ? -rem : rem);
          dbz   <= b_zero;
          state <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle into DONE, fixing latency at G_A_WIDTH+2 edges
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.q           = q;
  assign bus.r           = r;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_divide.sv
// Bench for divide: 8-bit and 18-bit unsigned/signed instances driven in pairs,
// results compared against an arithmetic reference model.
module tb_divide;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        grp18 = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] a_in = '0;
  logic [17:0] b_in = '0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  divide_if #(.A_W(8),  .B_W(8))  if_u8  ();
  divide_if #(.A_W(8),  .B_W(8))  if_s8  ();
  divide_if #(.A_W(18), .B_W(18)) if_u18 ();
  divide_if #(.A_W(18), .B_W(18)) if_s18 ();

  divide #(.G_A_WIDTH(8),  .G_B_WIDTH(8),  .G_SIGNED(0)) u_u8  (.clk(clk), .rst(rst), .bus(if_u8));
  divide #(.G_A_WIDTH(8),  .G_B_WIDTH(8),  .G_SIGNED(1)) u_s8  (.clk(clk), .rst(rst), .bus(if_s8));
  divide #(.G_A_WIDTH(18), .G_B_WIDTH(18), .G_SIGNED(0)) u_u18 (.clk(clk), .rst(rst), .bus(if_u18));
  divide #(.G_A_WIDTH(18), .G_B_WIDTH(18), .G_SIGNED(1)) u_s18 (.clk(clk), .rst(rst), .bus(if_s18));

  assign if_u8.in_valid   = in_valid & ~grp18;
  assign if_s8.in_valid   = in_valid & ~grp18;
  assign if_u18.in_valid  = in_valid & grp18;
  assign if_s18.in_valid  = in_valid & grp18;
  assign if_u8.out_ready  = out_ready & ~grp18;
  assign if_s8.out_ready  = out_ready & ~grp18;
  assign if_u18.out_ready = out_ready & grp18;
  assign if_s18.out_ready = out_ready & grp18;
  assign if_u8.a  = a_in[7:0];
  assign if_s8.a  = a_in[7:0];
  assign if_u8.b  = b_in[7:0];
  assign if_s8.b  = b_in[7:0];
  assign if_u18.a = a_in;
  assign if_s18.a = a_in;
  assign if_u18.b = b_in;
  assign if_s18.b = b_in;

  // Pair sharing a stimulus runs in lockstep, so the unsigned instance stands for the handshake
  wire c_in_ready  = grp18 ? if_u18.in_ready  : if_u8.in_ready;
  wire c_out_valid = grp18 ? if_u18.out_valid : if_u8.out_valid;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0..2 = q/r/div0 of unsigned instance, 3..5 = signed instance, of the active pair
  function automatic longint cur(input int which);
    case (which)
      0: return grp18 ? longint'(if_u18.q)           : longint'(if_u8.q);
      1: return grp18 ? longint'(if_u18.r)           : longint'(if_u8.r);
      2: return grp18 ? longint'(if_u18.div_by_zero) : longint'(if_u8.div_by_zero);
      3: return grp18 ? longint'(if_s18.q)           : longint'(if_s8.q);
      4: return grp18 ? longint'(if_s18.r)           : longint'(if_s8.r);
      default: return grp18 ? longint'(if_s18.div_by_zero) : longint'(if_s8.div_by_zero);
    endcase
  endfunction

  function automatic longint sext(input longint v, input int w);
    longint m = (longint'(1) << w) - 1;
    longint x = v & m;
    if (x[w-1]) x = x - (m + 1);
    return x;
  endfunction

  // Reference: plain integer division (truncating toward zero), wrapped to w bits
  function automatic void model(input longint a, input longint b, input int w, input bit sgn,
                                output longint q, output longint r, output bit z);
    longint m  = (longint'(1) << w) - 1;
    longint sa = sgn ? sext(a, w) : (a & m);
    longint sb = sgn ? sext(b, w) : (b & m);
    if (sb == 0) begin
      q = m; r = a & m; z = 1'b1;
    end else begin
      q = (sa / sb) & m; r = (sa % sb) & m; z = 1'b0;
    end
  endfunction

  task automatic do_op(input longint av, input longint bv, input int hold);
    int     g = grp18 ? 18 : 8;
    longint m = (longint'(1) << g) - 1;
    int     k;
    longint eq, er, qu, ru, qs, rs;
    bit     ez, zu, zs;
    @(negedge clk);
    a_in = av[17:0]; b_in = bv[17:0]; in_valid = 1'b1;
    k = 0;
    while (!c_in_ready && k < 50) begin @(negedge clk); k++; end
    if (!c_in_ready) begin
      chk("accept_timeout", c_in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = 18'($urandom); b_in = 18'($urandom);
    k = 0;
    do begin
      @(posedge clk); k++; @(negedge clk);
    end while (!c_out_valid && k < 100);
    chk("latency", k, g + 2);
    if (!c_out_valid) return;
    qu = cur(0); ru = cur(1); zu = cur(2) != 0;
    qs = cur(3); rs = cur(4); zs = cur(5) != 0;
    model(av, bv, g, 1'b0, eq, er, ez);
    chk("q_u", qu, eq); chk("r_u", ru, er); chk("dz_u", zu, ez);
    model(av, bv, g, 1'b1, eq, er, ez);
    chk("q_s", qs, eq); chk("r_s", rs, er); chk("dz_s", zs, ez);
    if ((bv & m) != 0)
      chk("ident_s", (sext(qs, g) * sext(bv, g) + sext(rs, g)) & m, av & m);
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin in_valid = 1'b1; a_in = 18'd3; b_in = 18'd1; end
      @(negedge clk);
      chk("hold_q", cur(0), qu);
      chk("hold_r", cur(4), rs);
      chk("hold_ir", c_in_ready, 0);
      chk("hold_ov", c_out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ov_clear", c_out_valid, 0);
    chk("ir_back", c_in_ready, 1);
  endtask

  initial begin
    longint av, bv;
    repeat (2) @(negedge clk);
    chk("rst_ir", c_in_ready, 0);
    chk("rst_ov", c_out_valid, 0);
    chk("rst_q", cur(0), 0);
    chk("rst_r", cur(4), 0);
    chk("rst_dz", cur(2), 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ir_release", c_in_ready, 1);

    do_op(200, 7, 0);
    do_op('hF9, 2, 0);
    do_op(7, 'hFE, 0);
    do_op('h80, 'hFF, 0);
    do_op(37, 0, 0);
    do_op(100, 9, 20);

    // reset in the middle of CALC
    @(negedge clk);
    a_in = 18'd50; b_in = 18'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ov", c_out_valid, 0);
    chk("midrst_ir", c_in_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_ir_rel", c_in_ready, 1);
    chk("midrst_ov_rel", c_out_valid, 0);
    do_op(9, 3, 0);

    grp18 = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0:       bv = 0;
        1:       bv = 'h3FFFF;
        2:       bv = $urandom_range(1, 15);
        default: bv = $urandom & 'h3FFFF;
      endcase
      av = ($urandom_range(0, 9) == 0) ? 'h20000 : ($urandom & 'h3FFFF);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(av, bv, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
